// File: rtl/riscv_hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
package riscv_hazard_pkg;

  // Forwarding select encodings for one EX source operand
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Default register-address width (32 architectural registers)
  localparam int unsigned RAW_DEF = 5;

endpackage

// File: rtl/forward_select.sv
// Forwarding select for a single EX source operand; MEM result beats WB result.
module forward_select
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned RAW = RAW_DEF
) (
  input  logic [RAW-1:0] rs_i,
  input  logic [RAW-1:0] rd_mem_i,
  input  logic           regwrite_mem_i,
  input  logic [RAW-1:0] rd_wb_i,
  input  logic           regwrite_wb_i,
  output logic [1:0]     fwd_c_o
);

  // x0 is never forwarded since it always reads as zero
  always_comb begin
    fwd_c_o = FWD_RF;
    if (regwrite_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i)) begin
      fwd_c_o = FWD_MEM;
    end else if (regwrite_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i)) begin
      fwd_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Data-hazard controller: EX forwarding, ID load-use detection, single
// outstanding long-op scoreboard and a saturating stall counter.
module hazard_scoreboard_unit
  import riscv_hazard_pkg::*;
#(
  parameter int unsigned NCH  = 2,
  parameter int unsigned RAW  = RAW_DEF,
  parameter int unsigned LATW = 4,
  parameter int unsigned CNTW = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NCH*RAW-1:0] RS_ID,
  input  logic [NCH-1:0]    RS_USED_ID,
  input  logic [RAW-1:0]    RD_ID,
  input  logic              REGWRITE_ID,
  input  logic              LONG_ID,
  input  logic [NCH*RAW-1:0] RS_EX,
  input  logic [RAW-1:0]    RD_EX,
  input  logic              REGWRITE_EX,
  input  logic              MEMREAD_EX,
  input  logic [RAW-1:0]    RD_MEM,
  input  logic              REGWRITE_MEM,
  input  logic [RAW-1:0]    RD_WB,
  input  logic              REGWRITE_WB,
  input  logic              LONG_ISSUE,
  input  logic [RAW-1:0]    LONG_RD,
  input  logic [LATW-1:0]   LONG_LAT,
  output logic [NCH*2-1:0]  FORWARD,
  output logic              STALL,
  output logic              LONG_BUSY,
  output logic              LONG_DONE,
  output logic [RAW-1:0]    LONG_RD_Q,
  output logic [CNTW-1:0]   STALL_CNT
);

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [RAW-1:0]  long_rd_q, long_rd_d;
  logic [LATW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic [NCH-1:0]  lu_hit;
  logic [NCH-1:0]  raw_hit;
  logic            load_use_c;
  logic            long_haz_c;
  logic            stall_c;

  // Per-channel forwarding selects and ID-side source comparisons
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    forward_select #(
      .RAW (RAW)
    ) u_fwd (
      .rs_i           (RS_EX[k*RAW +: RAW]),
      .rd_mem_i       (RD_MEM),
      .regwrite_mem_i (REGWRITE_MEM),
      .rd_wb_i        (RD_WB),
      .regwrite_wb_i  (REGWRITE_WB),
      .fwd_c_o        (FORWARD[k*2 +: 2])
    );

    assign lu_hit[k]  = RS_USED_ID[k] && (RS_ID[k*RAW +: RAW] == RD_EX);
    assign raw_hit[k] = RS_USED_ID[k] && (RS_ID[k*RAW +: RAW] == long_rd_q);
  end

  // Stall decision: load-use bubble or conflict with the outstanding long op
  always_comb begin
    load_use_c = MEMREAD_EX && REGWRITE_EX && (RD_EX != '0) && (|lu_hit);
    long_haz_c = 1'b0;
    if (busy_q && !done_q) begin
      long_haz_c = LONG_ID ||
                   ((long_rd_q != '0) &&
                    ((|raw_hit) || (REGWRITE_ID && (RD_ID == long_rd_q))));
    end
    stall_c = load_use_c || long_haz_c;
  end

  // Scoreboard next state; an issue is accepted when idle or in the done cycle
  always_comb begin
    busy_d    = busy_q;
    long_rd_d = long_rd_q;
    cnt_d     = cnt_q;
    if (LONG_ISSUE && (!busy_q || done_q)) begin
      busy_d    = 1'b1;
      long_rd_d = LONG_RD;
      cnt_d     = (LONG_LAT == '0) ? LATW'(1) : LONG_LAT;
    end else if (busy_q) begin
      if (done_q) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - LATW'(1);
      end
    end
    done_d = busy_d && (cnt_d == LATW'(1));
  end

  // Saturating performance counter of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      long_rd_q   <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      long_rd_q   <= long_rd_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL     = stall_c;
  assign LONG_BUSY = busy_q;
  assign LONG_DONE = done_q;
  assign LONG_RD_Q = long_rd_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: default instance plus a
// 4-channel instance with a 4-bit stall counter for saturation.
module tb_hazard_scoreboard_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  // Default instance signals (NCH=2, RAW=5, LATW=4, CNTW=32)
  logic [9:0]  rs_id, rs_ex;
  logic [1:0]  rs_used_id;
  logic [4:0]  rd_id, rd_ex, rd_mem, rd_wb, long_rd, long_rd_q;
  logic        regwrite_id, long_id, regwrite_ex, memread_ex;
  logic        regwrite_mem, regwrite_wb, long_issue;
  logic [3:0]  long_lat;
  logic [3:0]  fwd;
  logic        stall, long_busy, long_done;
  logic [31:0] stall_cnt;

  // Wide instance signals (NCH=4, CNTW=4)
  logic [19:0] s_rs_id, s_rs_ex;
  logic [3:0]  s_rs_used_id;
  logic [4:0]  s_rd_ex, s_rd_mem, s_long_rd_q;
  logic        s_regwrite_ex, s_memread_ex, s_regwrite_mem;
  logic [7:0]  s_fwd;
  logic        s_stall, s_long_busy, s_long_done;
  logic [3:0]  s_stall_cnt;

  hazard_scoreboard_unit dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .RS_ID        (rs_id),
    .RS_USED_ID   (rs_used_id),
    .RD_ID        (rd_id),
    .REGWRITE_ID  (regwrite_id),
    .LONG_ID      (long_id),
    .RS_EX        (rs_ex),
    .RD_EX        (rd_ex),
    .REGWRITE_EX  (regwrite_ex),
    .MEMREAD_EX   (memread_ex),
    .RD_MEM       (rd_mem),
    .REGWRITE_MEM (regwrite_mem),
    .RD_WB        (rd_wb),
    .REGWRITE_WB  (regwrite_wb),
    .LONG_ISSUE   (long_issue),
    .LONG_RD      (long_rd),
    .LONG_LAT     (long_lat),
    .FORWARD      (fwd),
    .STALL        (stall),
    .LONG_BUSY    (long_busy),
    .LONG_DONE    (long_done),
    .LONG_RD_Q    (long_rd_q),
    .STALL_CNT    (stall_cnt)
  );

  hazard_scoreboard_unit #(
    .NCH  (4),
    .RAW  (5),
    .LATW (4),
    .CNTW (4)
  ) dut_w (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .RS_ID        (s_rs_id),
    .RS_USED_ID   (s_rs_used_id),
    .RD_ID        (5'd0),
    .REGWRITE_ID  (1'b0),
    .LONG_ID      (1'b0),
    .RS_EX        (s_rs_ex),
    .RD_EX        (s_rd_ex),
    .REGWRITE_EX  (s_regwrite_ex),
    .MEMREAD_EX   (s_memread_ex),
    .RD_MEM       (s_rd_mem),
    .REGWRITE_MEM (s_regwrite_mem),
    .RD_WB        (5'd0),
    .REGWRITE_WB  (1'b0),
    .LONG_ISSUE   (1'b0),
    .LONG_RD      (5'd0),
    .LONG_LAT     (4'd0),
    .FORWARD      (s_fwd),
    .STALL        (s_stall),
    .LONG_BUSY    (s_long_busy),
    .LONG_DONE    (s_long_done),
    .LONG_RD_Q    (s_long_rd_q),
    .STALL_CNT    (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs_id = '0; rs_used_id = '0; rd_id = '0; regwrite_id = 0; long_id = 0;
    rs_ex = '0; rd_ex = '0; regwrite_ex = 0; memread_ex = 0;
    rd_mem = '0; regwrite_mem = 0; rd_wb = '0; regwrite_wb = 0;
    long_issue = 0; long_rd = '0; long_lat = '0;
    s_rs_id = '0; s_rs_ex = '0; s_rs_used_id = '0; s_rd_ex = '0;
    s_regwrite_ex = 0; s_memread_ex = 0; s_rd_mem = '0; s_regwrite_mem = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_chk++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd: got %b expected 0000", fwd); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_chk++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", long_busy); end
    n_chk++; if (long_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", long_done); end
    n_chk++; if (long_rd_q !== 5'd0) begin n_fail++; $display("FAIL reset_rd_q: got %0d expected 0", long_rd_q); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    rs_ex = {5'd0, 5'd5}; rd_mem = 5'd5; rd_wb = 5'd5; regwrite_mem = 1; regwrite_wb = 1;
    #1;
    n_chk++; if (fwd !== 4'b0010) begin n_fail++; $display("FAIL fwd_mem_priority: got %b expected 0010", fwd); end
    regwrite_mem = 0;
    #1;
    n_chk++; if (fwd !== 4'b0001) begin n_fail++; $display("FAIL fwd_wb: got %b expected 0001", fwd); end
    rs_ex = '0; rd_mem = '0; rd_wb = '0; regwrite_mem = 1; regwrite_wb = 1;
    #1;
    n_chk++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0: got %b expected 0000", fwd); end
    rs_ex = {5'd7, 5'd6}; rd_mem = 5'd6; rd_wb = 5'd7;
    #1;
    n_chk++; if (fwd !== 4'b0110) begin n_fail++; $display("FAIL fwd_split: got %b expected 0110", fwd); end
    idle_inputs();
    #1;
  endtask

  task automatic test_load_use();
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL lu_cnt_start: got %0d expected 0", stall_cnt); end
    memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd7; rs_id = {5'd7, 5'd3}; rs_used_id = 2'b10;
    #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b expected 1", stall); end
    tick();
    memread_ex = 0; regwrite_ex = 0; rd_ex = '0;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_after_bubble: got %b expected 0", stall); end
    n_chk++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
    memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd7; rs_used_id = 2'b01;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused_ch: got %b expected 0", stall); end
    rd_ex = 5'd0; rs_id = '0; rs_used_id = 2'b11;
    #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b expected 0", stall); end
    idle_inputs();
    tick();
    n_chk++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_long_op();
    long_issue = 1; long_rd = 5'd9; long_lat = 4'd4;
    tick();
    for (int c = 1; c <= 5; c++) begin
      rs_id = '0; rs_used_id = '0; rd_id = '0; regwrite_id = 0; long_id = 0;
      long_issue = 0;
      case (c)
        2: begin
          regwrite_id = 1; rd_id = 5'd9;
          long_issue = 1; long_rd = 5'd12; long_lat = 4'd9;
        end
        3: long_id = 1;
        default: begin rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01; end
      endcase
      #1;
      n_chk++; if (long_busy !== (c <= 4)) begin n_fail++; $display("FAIL long_busy c%0d: got %b expected %b", c, long_busy, (c <= 4)); end
      n_chk++; if (long_done !== (c == 4)) begin n_fail++; $display("FAIL long_done c%0d: got %b expected %b", c, long_done, (c == 4)); end
      n_chk++; if (stall !== (c <= 3)) begin n_fail++; $display("FAIL long_stall c%0d: got %b expected %b", c, stall, (c <= 3)); end
      if (c <= 4) begin
        n_chk++; if (long_rd_q !== 5'd9) begin n_fail++; $display("FAIL long_rd_q c%0d: got %0d expected 9", c, long_rd_q); end
      end
      tick();
    end
    idle_inputs();
    n_chk++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL long_cnt: got %0d expected 4", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    long_issue = 1; long_rd = 5'd3; long_lat = 4'd0;
    tick();
    long_issue = 1; long_rd = 5'd4; long_lat = 4'd2;
    rs_id = {5'd3, 5'd0}; rs_used_id = 2'b10;
    #1;
    n_chk++; if (long_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %b expected 1", long_busy); end
    n_chk++; if (long_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", long_done); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1: got %b expected 0", stall); end
    tick();
    long_issue = 0;
    #1;
    n_chk++; if (long_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2: got %b expected 1", long_busy); end
    n_chk++; if (long_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done2: got %b expected 0", long_done); end
    n_chk++; if (long_rd_q !== 5'd4) begin n_fail++; $display("FAIL b2b_rd_q: got %0d expected 4", long_rd_q); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_old_rd: got %b expected 0", stall); end
    rs_id = {5'd4, 5'd0};
    #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL b2b_new_rd: got %b expected 1", stall); end
    tick();
    n_chk++; if (long_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done3: got %b expected 1", long_done); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall3: got %b expected 0", stall); end
    tick();
    n_chk++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", long_busy); end
    n_chk++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 5", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    long_issue = 1; long_rd = 5'd9; long_lat = 4'd5;
    tick();
    long_issue = 0; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    repeat (3) tick();
    n_chk++; if (long_busy !== 1'b1 || long_done !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got busy %b done %b expected busy 1 done 0", long_busy, long_done); end
    n_chk++; if (stall_cnt !== 32'd8) begin n_fail++; $display("FAIL mid_pre_cnt: got %0d expected 8", stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (long_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", long_busy); end
    n_chk++; if (long_done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b expected 0", long_done); end
    n_chk++; if (long_rd_q !== 5'd0) begin n_fail++; $display("FAIL mid_rd_q: got %0d expected 0", long_rd_q); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", stall_cnt); end
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall: got %b expected 0", stall); end
    idle_inputs();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if (long_done !== 1'b0 || long_busy !== 1'b0) begin n_fail++; $display("FAIL mid_after %0d: got busy %b done %b expected 0 0", i, long_busy, long_done); end
    end
  endtask

  task automatic test_saturation();
    s_memread_ex = 1; s_regwrite_ex = 1; s_rd_ex = 5'd7;
    s_rs_id = {5'd7, 15'd0}; s_rs_used_id = 4'b1000;
    s_rs_ex = {5'd5, 15'd0}; s_rd_mem = 5'd5; s_regwrite_mem = 1;
    #1;
    n_chk++; if (s_stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall: got %b expected 1", s_stall); end
    n_chk++; if (s_fwd !== 8'b1000_0000) begin n_fail++; $display("FAIL sat_fwd_ch3: got %b expected 10000000", s_fwd); end
    repeat (14) tick();
    n_chk++; if (s_stall_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_cnt14: got %0d expected 14", s_stall_cnt); end
    repeat (3) tick();
    n_chk++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", s_stall_cnt); end
    s_rs_used_id = 4'b0111;
    #1;
    n_chk++; if (s_stall !== 1'b0) begin n_fail++; $display("FAIL sat_unused: got %b expected 0", s_stall); end
    n_chk++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL sat_narrow_isolated: got %0d expected 0", stall_cnt); end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_long_op();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
